ksm_busarb: RTL and testbench

Two-master Wishbone arbiter for the terminal's 16-bit system bus. It shares one slave-side bus between master 0 (the К1801ВМ2 CPU core, via its `wbm_gnt_i`) and master 1 (a secondary engine such as a video-memory fill/scroll DMA or a serial loader). The slave side feeds the existing address decoder, ack OR-tree and data mux unchanged. A transfer-timeout watchdog converts a missing slave ack into an error strobe to the owning master, so a bad address cannot hang the bus.

---
 rtl/ksm_busarb_if.sv | 51 +++++
 rtl/ksm_busarb.sv | 83 ++++++++
 tb/tb_ksm_busarb.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ksm_busarb_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master ports, the shared
// slave side and the arbiter status outputs.
interface ksm_busarb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [1:0]    m0_sel_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o, m0_gnt_o;

    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [1:0]    m1_sel_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o, m1_gnt_o;

    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [1:0]    s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;

    logic          owner_o, tmo_o;

    // Arbiter's view of the bundle.
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_dat_o, m0_ack_o, m0_err_o, m0_gnt_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_dat_o, m1_ack_o, m1_err_o, m1_gnt_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i,
        output owner_o, tmo_o
    );

    // Environment's view: masters and slave fabric around the arbiter.
    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o, m0_err_o, m0_gnt_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o, m1_err_o, m1_gnt_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i,
        input  owner_o, tmo_o
    );
endinterface

// File: rtl/ksm_busarb.sv
// Two-master Wishbone arbiter with bus parking, cycle-boundary round-robin and a
// transfer watchdog that turns a missing slave ack into an error strobe.
module ksm_busarb #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int TMO  = 64,
    parameter int PARK = 0
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_n_i,
    ksm_busarb_if.slave  bus
);
    localparam int TW = $clog2(TMO) + 1;
    localparam logic [TW-1:0] TC = TW'(TMO - 1);

    typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} own_t;
    localparam own_t PARK_ST = (PARK != 0) ? OWN_M1 : OWN_M0;

    own_t          own, own_n;
    logic          abort, abort_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          sel1, own_cyc, oth_cyc;
    logic [AW-1:0] adr_mux;
    logic [DW-1:0] dat_mux;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            own   <= PARK_ST;
            abort <= 1'b0;
            tcnt  <= '0;
        end else begin
            own   <= own_n;
            abort <= abort_n;
            tcnt  <= tcnt_n;
        end
    end

    // Ownership only moves at cycle boundaries; an active owner is never preempted.
    always_comb begin
        own_n   = own;
        abort_n = 1'b0;
        tcnt_n  = '0;
        own_cyc = (own == OWN_M1) ? bus.m1_cyc_i : bus.m0_cyc_i;
        oth_cyc = (own == OWN_M1) ? bus.m0_cyc_i : bus.m1_cyc_i;
        if (own_cyc)
            own_n = own;
        else if (oth_cyc)
            own_n = (own == OWN_M0) ? OWN_M1 : OWN_M0;
        else
            own_n = PARK_ST;
        // An ack on the terminal-count clock wins over the timeout.
        if (bus.s_stb_o && !bus.s_ack_i) begin
            if (tcnt == TC)
                abort_n = 1'b1;
            else
                tcnt_n = tcnt + 1'b1;
        end
    end

    always_comb begin
        sel1    = (own == OWN_M1);
        adr_mux = sel1 ? bus.m1_adr_i : bus.m0_adr_i;
        dat_mux = sel1 ? bus.m1_dat_i : bus.m0_dat_i;

        bus.s_cyc_o = sel1 ? bus.m1_cyc_i : bus.m0_cyc_i;
        bus.s_stb_o = (sel1 ? bus.m1_stb_i : bus.m0_stb_i) & ~abort;
        bus.s_we_o  = sel1 ? bus.m1_we_i  : bus.m0_we_i;
        bus.s_sel_o = sel1 ? bus.m1_sel_i : bus.m0_sel_i;
        bus.s_adr_o = adr_mux;
        bus.s_dat_o = dat_mux;

        bus.m0_ack_o = bus.s_ack_i & ~sel1 & bus.m0_stb_i;
        bus.m1_ack_o = bus.s_ack_i &  sel1 & bus.m1_stb_i;
        bus.m0_dat_o = sel1 ? '0 : bus.s_dat_i;
        bus.m1_dat_o = sel1 ? bus.s_dat_i : '0;
        bus.m0_err_o = abort & ~sel1;
        bus.m1_err_o = abort &  sel1;
        bus.m0_gnt_o = ~sel1;
        bus.m1_gnt_o = sel1;
        bus.owner_o  = sel1;
        bus.tmo_o    = abort;
    end
endmodule

// File: tb/tb_ksm_busarb.sv
// Randomized bench for ksm_busarb against a cycle-level behavioural model of
// ownership, the mux/return paths and the watchdog.
module tb_ksm_busarb;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    ksm_busarb_if #(.AW(AW), .DW(DW)) bus ();

    ksm_busarb #(.AW(AW), .DW(DW), .TMO(TMO), .PARK(0)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    logic          cyc [2];
    logic          stb [2];
    logic          we  [2];
    logic [1:0]    sel [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dat [2];
    logic          s_ack;
    logic [DW-1:0] s_dat;

    assign bus.m0_cyc_i = cyc[0];
    assign bus.m0_stb_i = stb[0];
    assign bus.m0_we_i  = we[0];
    assign bus.m0_sel_i = sel[0];
    assign bus.m0_adr_i = adr[0];
    assign bus.m0_dat_i = dat[0];
    assign bus.m1_cyc_i = cyc[1];
    assign bus.m1_stb_i = stb[1];
    assign bus.m1_we_i  = we[1];
    assign bus.m1_sel_i = sel[1];
    assign bus.m1_adr_i = adr[1];
    assign bus.m1_dat_i = dat[1];
    assign bus.s_ack_i  = s_ack;
    assign bus.s_dat_i  = s_dat;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference state: owning master, consecutive unacked strobe clocks seen so
    // far, and whether the current clock is the error clock.
    int unsigned m_own;
    int unsigned m_wait;
    bit          m_abort;
    bit          act  [2];
    bit          done [2];
    bit          start_en [2];
    int unsigned n_tmo_seen;

    task automatic model_reset();
        m_own   = 0;
        m_wait  = 0;
        m_abort = 0;
    endtask

    task automatic new_xfer(input int x);
        act[x] = 1;
        cyc[x] = 1'b1;
        stb[x] = 1'b1;
        we[x]  = 1'($urandom_range(0, 1));
        sel[x] = 2'($urandom_range(1, 3));
        adr[x] = AW'($urandom);
        dat[x] = DW'($urandom);
    endtask

    task automatic idle_master(input int x);
        act[x] = 0;
        cyc[x] = 1'b0;
        stb[x] = 1'b0;
        done[x] = 0;
    endtask

    // One bus clock: entered just after a rising edge, leaves just after the next.
    // mode 0: random acks; 1: slave never acks; 2: slave acks only on the terminal clock.
    task automatic run_cycle(input int mode);
        bit e_stb, e_ack [2], e_err [2];
        int unsigned o;
        for (int x = 0; x < 2; x++) begin
            if (done[x]) begin
                done[x] = 0;
                if (mode == 0 && $urandom_range(0, 1) == 0) new_xfer(x);
                else idle_master(x);
            end
            if (!act[x] && start_en[x] && $urandom_range(0, 2) == 0) new_xfer(x);
        end
        o = m_own;
        case (mode)
            0:       s_ack = ($urandom_range(0, 3) == 0);
            1:       s_ack = 1'b0;
            default: s_ack = (m_wait == TMO - 1);
        endcase
        s_dat = DW'($urandom);
        #8;
        e_stb = stb[o] && !m_abort;
        for (int x = 0; x < 2; x++) begin
            e_ack[x] = s_ack && (o == x) && stb[x];
            e_err[x] = m_abort && (o == x);
        end
        check("owner",  32'(bus.owner_o),  32'(o));
        check("gnt0",   32'(bus.m0_gnt_o), 32'(o == 0));
        check("gnt1",   32'(bus.m1_gnt_o), 32'(o == 1));
        check("s_cyc",  32'(bus.s_cyc_o),  32'(cyc[o]));
        check("s_stb",  32'(bus.s_stb_o),  32'(e_stb));
        check("s_we",   32'(bus.s_we_o),   32'(we[o]));
        check("s_sel",  32'(bus.s_sel_o),  32'(sel[o]));
        check("s_adr",  32'(bus.s_adr_o),  32'(adr[o]));
        check("s_dat",  32'(bus.s_dat_o),  32'(dat[o]));
        check("ack0",   32'(bus.m0_ack_o), 32'(e_ack[0]));
        check("ack1",   32'(bus.m1_ack_o), 32'(e_ack[1]));
        check("err0",   32'(bus.m0_err_o), 32'(e_err[0]));
        check("err1",   32'(bus.m1_err_o), 32'(e_err[1]));
        check("dat0",   32'(bus.m0_dat_o), (o == 0) ? 32'(s_dat) : 32'd0);
        check("dat1",   32'(bus.m1_dat_o), (o == 1) ? 32'(s_dat) : 32'd0);
        check("tmo",    32'(bus.tmo_o),    32'(m_abort));
        if (m_abort) n_tmo_seen++;

        for (int x = 0; x < 2; x++) if (e_ack[x] || e_err[x]) done[x] = 1;
        if (!cyc[o]) begin
            if (cyc[1 - o]) m_own = 1 - o;
            else m_own = 0;
        end
        if (!e_stb || s_ack) begin
            m_wait = 0;  m_abort = 0;
        end else if (m_wait == TMO - 1) begin
            m_wait = 0;  m_abort = 1;
        end else begin
            m_wait = m_wait + 1;  m_abort = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        for (int x = 0; x < 2; x++) begin
            idle_master(x);
            we[x] = 1'b0;  sel[x] = '0;  adr[x] = '0;  dat[x] = '0;
            start_en[x] = 1;
        end
        s_ack = 1'b0;
        s_dat = '0;
        n_tmo_seen = 0;
        model_reset();

        #5;
        check("rst_owner", 32'(bus.owner_o),  32'd0);
        check("rst_gnt0",  32'(bus.m0_gnt_o), 32'd1);
        check("rst_gnt1",  32'(bus.m1_gnt_o), 32'd0);
        check("rst_tmo",   32'(bus.tmo_o),    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) run_cycle(0);

        // Watchdog: one master at a time stalls, then both contend.
        idle_master(0);  idle_master(1);
        start_en[1] = 0;
        for (int i = 0; i < 140; i++) run_cycle(1);
        start_en[0] = 0;  start_en[1] = 1;
        for (int i = 0; i < 140; i++) run_cycle(1);
        start_en[0] = 1;
        for (int i = 0; i < 200; i++) run_cycle(1);
        check("tmo_pulses_seen", 32'(n_tmo_seen > 3), 32'd1);
        for (int i = 0; i < 200; i++) run_cycle(2);

        // Reset while m1 owns the bus with a strobe pending.
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            run_cycle(0);
            if (m_own == 1 && stb[1] && !done[1]) found = 1;
        end
        check("rst_hunt", 32'(found), 32'd1);
        #4;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mrst_owner", 32'(bus.owner_o),  32'd0);
        check("mrst_gnt1",  32'(bus.m1_gnt_o), 32'd0);
        check("mrst_err1",  32'(bus.m1_err_o), 32'd0);
        check("mrst_tmo",   32'(bus.tmo_o),    32'd0);
        check("mrst_s_stb", 32'(bus.s_stb_o),  32'(stb[0]));
        check("mrst_s_adr", 32'(bus.s_adr_o),  32'(adr[0]));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) run_cycle(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
